// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with frame-aligned
// double buffering and per-slot PWM brightness.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic [3:0]              slot_idx,
    output logic                    frame_start
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int LW = PW + 5;

    logic [PW-1:0]           r_presc;
    logic [3:0]              r_slot;
    logic [3:0]              r_bright;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;
    logic                    r_frame;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [7:0]              r_cathode;

    logic          w_tick;
    logic          w_wrap;
    logic [SW-1:0] w_sel;
    logic [3:0]    w_nib;
    logic [LW-1:0] w_prod;
    logic [LW-1:0] w_on_limit;
    logic          w_active;
    logic [6:0]    w_seg;

    assign w_tick     = r_presc == PW'(REFRESH_DIV - 1);
    assign w_wrap     = w_tick && (r_slot == 4'(NUM_DIGITS - 1));
    assign w_sel      = r_slot[SW-1:0];
    assign w_nib      = r_disp[{w_sel, 2'b00} +: 4];
    // Sized so (15+1)*REFRESH_DIV never overflows before the shift.
    assign w_prod     = LW'({1'b0, r_bright} + 5'd1) * LW'(REFRESH_DIV);
    assign w_on_limit = w_prod >> 4;
    assign w_active   = (r_presc != '0) && (LW'(r_presc) < w_on_limit) && digit_en[w_sel];

    // Active-low {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            r_presc      <= '0;
            r_slot       <= '0;
            r_bright     <= '0;
            r_disp       <= '0;
            r_disp_dp    <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_frame      <= 1'b0;
            r_anode      <= '1;
            r_cathode    <= 8'hFF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_slot <= w_wrap ? '0 : r_slot + 4'd1;
            r_frame <= w_wrap;
            if (r_presc == '0)
                r_bright <= brightness;
            // Display only changes on the frame wrap, so a frame never tears.
            if (w_wrap && load) begin
                r_disp       <= digits_in;
                r_disp_dp    <= dp_in;
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend       <= digits_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end else if (w_wrap && r_pend_valid) begin
                r_disp       <= r_pend;
                r_disp_dp    <= r_pend_dp;
                r_pend_valid <= 1'b0;
            end
            r_anode   <= w_active ? ~(NUM_DIGITS'(1) << w_sel) : '1;
            r_cathode <= w_active ? {~r_disp_dp[w_sel], w_seg} : 8'hFF;
        end
    end

    assign anode       = r_anode;
    assign cathode     = r_cathode;
    assign slot_idx    = r_slot;
    assign frame_start = r_frame;
endmodule
